// File: rtl/fp_uart_pkg.sv
// fp_uart_pkg
// Shared types and constants for the FP-over-UART calculator protocol.
// Imported by the client (and optionally by the server side).
//   state_t    : protocol FSM states
//   OP_BYTES   : bytes sent per request (two 32-bit operands)
//   RES_BYTES  : bytes received per response (one 32-bit result)
//   cnt_t      : byte counter type, wide enough for OP_BYTES
package fp_uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND    = 3'd1,
        TX_WAIT = 3'd2,
        RECV    = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int OP_BYTES  = 8;
    localparam int RES_BYTES = 4;
    localparam int CNT_W     = $clog2(OP_BYTES);

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/fp_uart_client_edge.sv
// posedgeDect
// Rising-edge detector producing a registered one-cycle pulse.
// A level that stays high produces exactly one pulse.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   i_sig   : level input (uart rx-done level)
//   o_pulse : one-cycle pulse, one clock after the rising edge is sampled
module posedgeDect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_pulse
);

    logic r_prev;
    logic r_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_prev  <= i_sig;
            r_pulse <= i_sig & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/fp_uart_client.sv
// fp_uart_client
// Host-side initiator for the FP-over-UART calculator. Sends op1 then op2
// (8 bytes, MSB byte first) through a uart byte interface, then collects a
// 4-byte result (MSB first) and presents it with a one-cycle valid strobe.
//
// Optional build macro: FP_CLIENT_TIMEOUT_EN enables a response timeout of
// TIMEOUT_CYCLES clocks while waiting for result bytes. Without it, timeout
// is tied low and the block waits for the reply indefinitely.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, op1, op2       : request and operands (accepted only when ready)
//   ready                 : high only in IDLE
//   result, result_valid  : last complete result and its one-cycle strobe
//   timeout               : one-cycle strobe on response timeout
//   send_data, tx_data    : byte send request to the uart transmitter
//   tx_done               : uart transmitter finished the byte
//   rx_done_raw, rx_data  : uart receive-done level and received byte
module fp_uart_client
    import fp_uart_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic        ready,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        timeout,
    output logic        send_data,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    input  logic        rx_done_raw,
    input  logic [7:0]  rx_data
);

    state_t      r_state, w_state_next;
    cnt_t        r_cnt, w_cnt_next;
    logic [63:0] r_shreg, w_shreg_next;
    logic [31:0] r_acc, w_acc_next;
    logic [31:0] r_result, w_result_next;
    logic        r_result_valid, w_result_valid_next;
    logic        r_send_data, w_send_data_next;
    logic [7:0]  r_tx_data, w_tx_data_next;
    logic        w_rx_pulse;
    logic        w_to_hit;

    posedgeDect u_rx_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_sig   (rx_done_raw),
        .o_pulse (w_rx_pulse)
    );

`ifdef FP_CLIENT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout;

    // A byte arriving in the same cycle as expiry wins over the timeout.
    assign w_to_hit = (r_state == RECV) && !w_rx_pulse && (r_to_cnt == TO_LAST);

    // Held at zero outside RECV, so it always starts from zero on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if ((r_state != RECV) || w_rx_pulse || w_to_hit) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            r_timeout <= w_to_hit;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_to_hit = 1'b0;
    assign timeout  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_shreg        <= '0;
            r_acc          <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_send_data    <= 1'b0;
            r_tx_data      <= '0;
        end else begin
            r_state        <= w_state_next;
            r_cnt          <= w_cnt_next;
            r_shreg        <= w_shreg_next;
            r_acc          <= w_acc_next;
            r_result       <= w_result_next;
            r_result_valid <= w_result_valid_next;
            r_send_data    <= w_send_data_next;
            r_tx_data      <= w_tx_data_next;
        end
    end

    always_comb begin
        w_state_next        = r_state;
        w_cnt_next          = r_cnt;
        w_shreg_next        = r_shreg;
        w_acc_next          = r_acc;
        w_result_next       = r_result;
        w_result_valid_next = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_shreg_next = {op1, op2};
                    w_acc_next   = '0;
                    w_cnt_next   = '0;
                    w_state_next = SEND;
                end
            end
            SEND: begin
                w_state_next = TX_WAIT;
            end
            TX_WAIT: begin
                if (tx_done) begin
                    w_shreg_next = {r_shreg[55:0], 8'h00};
                    if (r_cnt == cnt_t'(OP_BYTES - 1)) begin
                        w_cnt_next   = '0;
                        w_state_next = RECV;
                    end else begin
                        w_cnt_next   = r_cnt + 1'b1;
                        w_state_next = SEND;
                    end
                end
            end
            RECV: begin
                if (w_rx_pulse) begin
                    w_acc_next = {r_acc[23:0], rx_data};
                    if (r_cnt == cnt_t'(RES_BYTES - 1)) begin
                        // Result and strobe are registered on DONE entry so
                        // both are visible during the DONE cycle itself.
                        w_cnt_next          = '0;
                        w_result_next       = {r_acc[23:0], rx_data};
                        w_result_valid_next = 1'b1;
                        w_state_next        = DONE;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end else if (w_to_hit) begin
                    w_cnt_next   = '0;
                    w_acc_next   = '0;
                    w_state_next = IDLE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // send_data is high exactly while in SEND; tx_data carries the top
        // byte of the (possibly just shifted) shift register and otherwise holds.
        w_send_data_next = (w_state_next == SEND);
        w_tx_data_next   = w_send_data_next ? w_shreg_next[63:56] : r_tx_data;
    end

    assign ready        = (r_state == IDLE);
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign send_data    = r_send_data;
    assign tx_data      = r_tx_data;

endmodule

// File: tb/tb_fp_uart_client.sv
module tb_fp_uart_client;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        ready;
    logic [31:0] result;
    logic        result_valid;
    logic        timeout;
    logic        send_data;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        rx_done_raw;
    logic [7:0]  rx_data;

    fp_uart_client #(.TIMEOUT_CYCLES(1000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .op1          (op1),
        .op2          (op2),
        .ready        (ready),
        .result       (result),
        .result_valid (result_valid),
        .timeout      (timeout),
        .send_data    (send_data),
        .tx_data      (tx_data),
        .tx_done      (tx_done),
        .rx_done_raw  (rx_done_raw),
        .rx_data      (rx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] reply;
        int          hold;
        bit          spam;
        bit          stray;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t        tab[5];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          tx_count = 0;
    int          busy = 0;
    logic [7:0]  held_byte = 8'h00;
    int          res_seen = 0;
    int          to_seen = 0;
    int          to_cyc = 0;
    int          rise_cyc = 0;
    logic        prev_valid = 1'b0;
    logic [31:0] last_result = 32'h0;
    logic [7:0]  exp_tx_q[$];
    logic [31:0] exp_res_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // UART transmitter model: accepts a byte on send_data and answers with
    // tx_done a few cycles later; checks byte order and tx_data stability.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                tx_done = 1'b0;
                busy    = 0;
            end else begin
                if (tx_done) tx_done = 1'b0;
                if (busy > 0) begin
                    chk("send_overlap", {31'b0, send_data}, 32'h0);
                    chk("tx_stable", {24'b0, tx_data}, {24'b0, held_byte});
                    busy--;
                    if (busy == 0) tx_done = 1'b1;
                end else if (send_data) begin
                    tx_count++;
                    held_byte = tx_data;
                    if (exp_tx_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_unexpected: got byte %h, none expected", tx_data);
                    end else begin
                        chk("tx_byte", {24'b0, tx_data}, {24'b0, exp_tx_q.pop_front()});
                    end
                    $display("tx byte %h (cycle %0d)", tx_data, cyc);
                    busy = $urandom_range(2, 6);
                end
            end
        end
    end

    // Result/timeout monitor: pops the result scoreboard on each strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (result_valid) begin
                    res_seen++;
                    chk("valid_width", {31'b0, prev_valid}, 32'h0);
                    if (exp_res_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL result_unexpected: got %h, none expected", result);
                    end else begin
                        chk("result", result, exp_res_q.pop_front());
                    end
                    last_result = result;
                    $display("result %h (cycle %0d)", result, cyc);
                end
                prev_valid = result_valid;
                if (timeout) begin
                    to_seen++;
                    to_cyc = cyc;
                    $display("timeout strobe (cycle %0d)", cyc);
                end
            end else begin
                prev_valid = 1'b0;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic do_send(input vec_t v, input bit expect_res, output int base);
        int n;
        n = 0;
        while (!ready && n < 2000) begin
            step();
            n++;
        end
        chk("ready_before_start", {31'b0, ready}, 32'h1);
        base  = tx_count;
        start = 1'b1;
        op1   = v.op1;
        op2   = v.op2;
        for (int b = 0; b < 4; b++) exp_tx_q.push_back(v.op1[31-8*b -: 8]);
        for (int b = 0; b < 4; b++) exp_tx_q.push_back(v.op2[31-8*b -: 8]);
        if (expect_res) exp_res_q.push_back(v.exp);
        step();
        chk("first_send_lat", {31'b0, send_data}, 32'h1);
        chk("ready_busy", {31'b0, ready}, 32'h0);
        start = v.spam ? 1'b1 : 1'b0;
        op1   = $urandom;
        op2   = $urandom;
        if (v.stray) begin
            rx_data     = 8'h55;
            rx_done_raw = 1'b1;
        end
        n = 0;
        while (!(tx_count == base + 8 && busy == 0 && !tx_done) && n < 600) begin
            step();
            n++;
            if (v.stray && n == 2) rx_done_raw = 1'b0;
            if (v.spam) start = 1'($urandom_range(0, 1));
        end
        chk("tx_count", tx_count - base, 32'd8);
    endtask

    task automatic do_reply(input vec_t v, input int nb);
        for (int b = 0; b < nb; b++) begin
            bit last;
            last        = (b == 3);
            rx_data     = v.reply[31-8*b -: 8];
            rx_done_raw = 1'b1;
            rise_cyc    = cyc;
            if (last) start = 1'b0;
            for (int c = 0; c < v.hold; c++) begin
                step();
                if (last && c == 0) chk("valid_early", {31'b0, result_valid}, 32'h0);
                if (last && c == 1) chk("valid_lat", {31'b0, result_valid}, 32'h1);
                if (last && c == 2) chk("ready_after", {31'b0, ready}, 32'h1);
                if (!last && v.spam) start = 1'($urandom_range(0, 1));
            end
            rx_done_raw = 1'b0;
            repeat (3) begin
                step();
                if (!last && v.spam) start = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic run_txn(input vec_t v);
        int base;
        int seen0;
        seen0 = res_seen;
        do_send(v, 1'b1, base);
        do_reply(v, 4);
        chk("no_extra_tx", tx_count - base, 32'd8);
        chk("one_result", res_seen - seen0, 32'd1);
        $display("txn %s op1=%h op2=%h result=%h", v.name, v.op1, v.op2, result);
    endtask

    initial begin
        int base;
        int n;
        start       = 1'b0;
        op1         = '0;
        op2         = '0;
        rx_done_raw = 1'b0;
        rx_data     = '0;
        rst_n       = 1'b0;
        repeat (3) step();
        chk("rst_ready", {31'b0, ready}, 32'h1);
        chk("rst_result", result, 32'h0);
        chk("rst_valid", {31'b0, result_valid}, 32'h0);
        chk("rst_timeout", {31'b0, timeout}, 32'h0);
        chk("rst_send", {31'b0, send_data}, 32'h0);
        chk("rst_txdata", {24'b0, tx_data}, 32'h0);
        rst_n = 1'b1;
        repeat (2) step();

        tab[0] = '{32'h3FC00000, 32'h40000000, 32'h40400000,   3, 1'b0, 1'b0, 32'h40400000, "basic"};
        tab[1] = '{32'h11223344, 32'h55667788, 32'hCAFEBABE,   4, 1'b1, 1'b0, 32'hCAFEBABE, "start_spam"};
        tab[2] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'hDEADBEEF, 500, 1'b0, 1'b0, 32'hDEADBEEF, "long_level"};
        tab[3] = '{32'h01020304, 32'h05060708, 32'h12345678,   3, 1'b0, 1'b1, 32'h12345678, "stray_byte"};
        tab[4] = '{32'hFFFFFFFF, 32'h00000000, 32'hFF00FF00,   5, 1'b0, 1'b0, 32'hFF00FF00, "edges"};

        for (int i = 0; i < 5; i++) run_txn(tab[i]);

        // Reset in the middle of collecting the result.
        do_send(tab[4], 1'b0, base);
        do_reply(tab[1], 2);
        rst_n = 1'b0;
        step();
        chk("mid_rst_ready", {31'b0, ready}, 32'h1);
        chk("mid_rst_result", result, 32'h0);
        chk("mid_rst_valid", {31'b0, result_valid}, 32'h0);
        chk("mid_rst_send", {31'b0, send_data}, 32'h0);
        chk("mid_rst_txdata", {24'b0, tx_data}, 32'h0);
        chk("mid_rst_timeout", {31'b0, timeout}, 32'h0);
        exp_tx_q.delete();
        exp_res_q.delete();
        rst_n = 1'b1;
        repeat (2) step();
        last_result = result;
        run_txn(tab[0]);

`ifdef FP_CLIENT_TIMEOUT_EN
        begin
            int to0;
            int rs0;
            logic [31:0] keep;
            to0  = to_seen;
            rs0  = res_seen;
            keep = result;
            do_send(tab[3], 1'b0, base);
            do_reply(tab[2], 2);
            n = 0;
            while (to_seen == to0 && n < 1300) begin
                step();
                n++;
            end
            chk("timeout_seen", to_seen - to0, 32'd1);
            checks++;
            if ((to_cyc - rise_cyc) < 995 || (to_cyc - rise_cyc) > 1005) begin
                errors++;
                $display("FAIL timeout_delay: got %0d cycles expected about 1000", to_cyc - rise_cyc);
            end
            chk("timeout_result_kept", result, keep);
            chk("timeout_no_valid", res_seen - rs0, 32'd0);
            chk("timeout_ready", {31'b0, ready}, 32'h1);
            run_txn(tab[3]);
        end
`else
        chk("timeout_never", to_seen, 32'd0);
`endif

        chk("tx_queue_empty", exp_tx_q.size(), 32'd0);
        chk("res_queue_empty", exp_res_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_uart_client.md
Name: fp_uart_client

Overview:
Host-side initiator for the FP-over-UART calculator protocol. Takes two 32-bit operands from local logic and sends them as 8 bytes over a UART byte interface: op1 then op2, each MSB byte first. It then collects the 4-byte result (MSB first) and presents it as a 32-bit word with a one-cycle valid strobe. It sits between local control logic and an existing uart core in a test/master FPGA driving the calculator board.

Parameters:
TIMEOUT_CYCLES, 50000000, response-timeout limit in clk cycles (used only with the optional feature).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only while ready=1
op1  in  32  first operand, latched when start is accepted
op2  in  32  second operand, latched when start is accepted
ready  out  1  high only in IDLE
result  out  32  last complete result; holds until the next complete result
result_valid  out  1  one-cycle strobe when result updates
timeout  out  1  one-cycle strobe when a response timeout occurs; tied 0 without the feature
send_data  out  1  one-cycle pulse telling the uart to send tx_data
tx_data  out  8  byte to transmit; stable from the send_data pulse until tx_done
tx_done  in  1  single-cycle pulse from the uart when a byte has finished sending
rx_done_raw  in  1  uart receive-done level; may stay high for many cycles
rx_data  in  8  received byte; valid while rx_done_raw is high

Behaviour:
- Reset values:
  - ready=1, result=0, result_valid=0, timeout=0, send_data=0, tx_data=0.
  - Byte counter=0, state=IDLE.
- Clock and reset: a single clock domain. Asynchronous reset is legal at any time, including mid-transaction. It returns to IDLE and drops any partial operand or result. The bench must not expect a late byte to be resent.
- rx_done_raw goes through a rising-edge detector and becomes the registered one-cycle rx_pulse. A level held high counts as exactly one byte.
- States: IDLE, SEND, TX_WAIT, RECV, DONE.
- IDLE:
  - On start=1, load the 64-bit shift register with {op1,op2}, clear cnt to 0 and go to SEND.
  - start is ignored in every other state.
- SEND (one cycle):
  - send_data=1 and tx_data=shreg[63:56], both registered outputs.
  - Go to TX_WAIT.
- TX_WAIT:
  - On tx_done, shift shreg left by 8.
  - If cnt==7, clear cnt and go to RECV. Otherwise cnt+1 and go back to SEND.
  - tx_done seen outside TX_WAIT is ignored.
- RECV:
  - On rx_pulse, shift rx_data into the result assembly register: acc <= {acc[23:0], rx_data}.
  - When the 4th byte arrives (cnt==3), go to DONE. Otherwise cnt+1.
- DONE (one cycle):
  - result <= acc and result_valid=1 for exactly this cycle.
  - Return to IDLE. ready rises on the following cycle.
- rx_pulse outside RECV (stray bytes during SEND/TX_WAIT/IDLE) is dropped and does not touch acc.
- Latency:
  - First send_data comes 1 cycle after start is accepted.
  - result_valid comes 2 cycles after the rx_pulse-triggering rx_done_raw rise of byte 4: edge register plus DONE.
- tx_data stays at its last value between transactions.

Optional Feature:
- Macro: FP_CLIENT_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) runs only in RECV. It clears on RECV entry and on every accepted rx_pulse.
  - When it reaches TIMEOUT_CYCLES: timeout=1 for one cycle, result and result_valid are unchanged, acc is discarded, and the block goes to IDLE.
  - A simultaneous rx_pulse wins: the byte is accepted and the counter clears.
- Not defined: the counter is absent, timeout is tied 0, and RECV waits indefinitely.

Decomposition:
- Package fp_uart_pkg:
  - state_t enum.
  - Constants OP_BYTES=8 and RES_BYTES=4.
  - Byte-count width.
  - The server may import the same package.
- One natural sub-module: the existing rising-edge detector posedgeDect for rx_done_raw. Everything else stays in one FSM module.

Test Plan:
- Basic transaction: op1=0x3FC00000, op2=0x40000000, start -> tx bytes in order 3F C0 00 00 40 00 00 00, each only after the previous tx_done. The model then replies 40 40 00 00 -> result=0x40400000, result_valid high for exactly 1 cycle, ready back to 1.
- start pulsed repeatedly during SEND/RECV -> ignored; exactly 8 bytes sent and op latches unchanged.
- rx_done_raw held high 500 cycles per byte -> each byte counted once; result assembles 0xDEADBEEF from DE AD BE EF.
- Byte 0x55 injected during TX_WAIT -> ignored; the following reply 12 34 56 78 -> result=0x12345678.
- With FP_CLIENT_TIMEOUT_EN and TIMEOUT_CYCLES=1000, reply only 2 bytes -> timeout pulse 1000 cycles after the 2nd rx_pulse, result keeps its previous value, ready=1.
- Assert rst_n low after 2 result bytes -> all outputs take reset values. A fresh transaction then completes normally.
